split_arbiter: RTL

SPLIT_ARBITER -- requirements
Module: split_arbiter

---
 rtl/split_arbiter_pkg.sv | 36 +++
 rtl/split_arbiter_split_tracker.sv | 70 +++++++
 rtl/split_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/split_arbiter_pkg.sv
// Shared types and encodings for the split-transaction bus arbiter.
package split_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_BUSY    = 2'b10,
        ST_RELEASE = 2'b11
    } arb_state_t;

    // BUS_GRANT mux-select encodings.
    localparam logic [1:0] BUS_GRANT_NONE = 2'b00;
    localparam logic [1:0] BUS_GRANT_M1   = 2'b01;
    localparam logic [1:0] BUS_GRANT_M2   = 2'b10;

    // Slave-select encodings.
    localparam logic [1:0] SLV_S1      = 2'b00;
    localparam logic [1:0] SLV_S2      = 2'b01;
    localparam logic [1:0] SLV_S3      = 2'b10;
    localparam logic [1:0] SLV_INVALID = 2'b11;

    // One-hot slave vector matching the S_SPLIT_EN / S_SPLIT_READY bit order.
    function automatic logic [2:0] slave_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        oh = 3'b000;
        case (sel)
            SLV_S1:  oh = 3'b001;
            SLV_S2:  oh = 3'b010;
            SLV_S3:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/split_arbiter_split_tracker.sv
// Tracks the single outstanding split (owner, slave, ready flag) and
// derives which master requests are currently eligible for a normal grant.
module split_tracker
    import split_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rqst,            // bit0 = M1, bit1 = M2
    input  logic [1:0] m1_sel,
    input  logic [1:0] m2_sel,
    input  logic       split_record,    // BUSY saw a split from the selected slave
    input  logic       split_owner,     // 0 = M1 owns the split, 1 = M2
    input  logic [1:0] split_slave,
    input  logic       resume_grant,    // FSM is issuing the resume grant now
    input  logic [2:0] s_split_ready,
    output logic [1:0] eligible,        // bit0 = M1, bit1 = M2
    output logic       split_pending,
    output logic       resume_valid,
    output logic       resume_owner,    // 0 = M1, 1 = M2
    output logic [1:0] resume_slave,
    output logic       m1_parked,
    output logic       m2_parked
);

    logic [1:0] parked_reg;
    logic [1:0] slave_reg;
    logic       ready_reg;
    logic [1:0] sel_arr [2];

    assign sel_arr[0]    = m1_sel;
    assign sel_arr[1]    = m2_sel;
    assign split_pending = |parked_reg;
    assign resume_valid  = split_pending && ready_reg;
    assign resume_owner  = parked_reg[1];
    assign resume_slave  = slave_reg;
    assign m1_parked     = parked_reg[0];
    assign m2_parked     = parked_reg[1];

    // A request is eligible when it targets a real slave, its master is not
    // parked, and it does not target the slave that currently owns a split.
    // The owner returns through the resume path, not through this mask.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign eligible[gi] = rqst[gi]
                               && (sel_arr[gi] != SLV_INVALID)
                               && !parked_reg[gi]
                               && !(split_pending && (sel_arr[gi] == slave_reg));
        end
    endgenerate

    // Split record: set on a new split, cleared by the resume grant; the ready
    // flag only listens to the slave that owns the split.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parked_reg <= 2'b00;
            slave_reg  <= SLV_S1;
            ready_reg  <= 1'b0;
        end else if (resume_grant) begin
            parked_reg <= 2'b00;
            ready_reg  <= 1'b0;
        end else if (split_record && !split_pending) begin
            parked_reg <= split_owner ? 2'b10 : 2'b01;
            slave_reg  <= split_slave;
            ready_reg  <= 1'b0;
        end else if (split_pending && |(s_split_ready & slave_onehot(slave_reg))) begin
            ready_reg  <= 1'b1;
        end
    end

endmodule

// File: rtl/split_arbiter.sv
// Two-master, three-slave bus arbiter with round-robin fairness, a single
// outstanding split transaction, and a BUSY watchdog timeout.
module split_arbiter
    import split_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       MASTER_CLK,
    input  logic       MASTER_RST,
    input  logic       M1_RQST,
    input  logic       M2_RQST,
    input  logic [1:0] M1_SLAVE_SEL,
    input  logic [1:0] M2_SLAVE_SEL,
    input  logic       TX_DONE,
    input  logic [2:0] S_SPLIT_EN,
    input  logic [2:0] S_SPLIT_READY,
    output logic       M1_GRANT,
    output logic       M2_GRANT,
    output logic [1:0] BUS_GRANT,
    output logic [1:0] SLAVE_SELECT,
    output logic       ARB_BUSY,
    output logic       BUS_BUSY,
    output logic       M1_SPLIT,
    output logic       M2_SPLIT,
    output logic       TIMEOUT
);

    localparam logic [9:0] COUNT_LAST = 10'(TIMEOUT_CYCLES - 1);

    arb_state_t state_reg, state_next;
    logic [9:0] count_reg, count_next;
    logic       rr_m2_reg, rr_m2_next;      // 1: M2 wins the next tie
    logic       m1_grant_reg, m1_grant_next;
    logic       m2_grant_reg, m2_grant_next;
    logic [1:0] bus_grant_reg, bus_grant_next;
    logic [1:0] slave_select_reg, slave_select_next;
    logic       arb_busy_reg, arb_busy_next;
    logic       bus_busy_reg, bus_busy_next;
    logic       timeout_reg, timeout_next;

    logic       split_record;
    logic       split_owner;
    logic       resume_grant;
    logic [1:0] eligible;
    logic       split_pending;
    logic       resume_valid;
    logic       resume_owner;
    logic [1:0] resume_slave;
    logic       pick_m2;

    split_tracker u_split_tracker (
        .clk           (MASTER_CLK),
        .rst_n         (MASTER_RST),
        .rqst          ({M2_RQST, M1_RQST}),
        .m1_sel        (M1_SLAVE_SEL),
        .m2_sel        (M2_SLAVE_SEL),
        .split_record  (split_record),
        .split_owner   (split_owner),
        .split_slave   (slave_select_reg),
        .resume_grant  (resume_grant),
        .s_split_ready (S_SPLIT_READY),
        .eligible      (eligible),
        .split_pending (split_pending),
        .resume_valid  (resume_valid),
        .resume_owner  (resume_owner),
        .resume_slave  (resume_slave),
        .m1_parked     (M1_SPLIT),
        .m2_parked     (M2_SPLIT)
    );

    assign M1_GRANT     = m1_grant_reg;
    assign M2_GRANT     = m2_grant_reg;
    assign BUS_GRANT    = bus_grant_reg;
    assign SLAVE_SELECT = slave_select_reg;
    assign ARB_BUSY     = arb_busy_reg;
    assign BUS_BUSY     = bus_busy_reg;
    assign TIMEOUT      = timeout_reg;

    // State, counter, round-robin pointer and all registered outputs.
    always_ff @(posedge MASTER_CLK or negedge MASTER_RST) begin
        if (!MASTER_RST) begin
            state_reg        <= ST_IDLE;
            count_reg        <= '0;
            rr_m2_reg        <= 1'b0;
            m1_grant_reg     <= 1'b0;
            m2_grant_reg     <= 1'b0;
            bus_grant_reg    <= BUS_GRANT_NONE;
            slave_select_reg <= SLV_S1;
            arb_busy_reg     <= 1'b0;
            bus_busy_reg     <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            rr_m2_reg        <= rr_m2_next;
            m1_grant_reg     <= m1_grant_next;
            m2_grant_reg     <= m2_grant_next;
            bus_grant_reg    <= bus_grant_next;
            slave_select_reg <= slave_select_next;
            arb_busy_reg     <= arb_busy_next;
            bus_busy_reg     <= bus_busy_next;
            timeout_reg      <= timeout_next;
        end
    end

    // Next-state and next-output logic; a resumed split beats round-robin,
    // and in BUSY the priority is TX_DONE, then split, then timeout.
    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        rr_m2_next        = rr_m2_reg;
        m1_grant_next     = m1_grant_reg;
        m2_grant_next     = m2_grant_reg;
        bus_grant_next    = bus_grant_reg;
        slave_select_next = slave_select_reg;
        timeout_next      = 1'b0;
        split_record      = 1'b0;
        split_owner       = m2_grant_reg;
        resume_grant      = 1'b0;
        pick_m2           = eligible[1] && (!eligible[0] || rr_m2_reg);

        case (state_reg)
            ST_IDLE: begin
                if (resume_valid) begin
                    resume_grant      = 1'b1;
                    state_next        = ST_GRANT;
                    count_next        = '0;
                    m1_grant_next     = !resume_owner;
                    m2_grant_next     = resume_owner;
                    bus_grant_next    = resume_owner ? BUS_GRANT_M2 : BUS_GRANT_M1;
                    slave_select_next = resume_slave;
                    rr_m2_next        = !resume_owner;
                end else if (|eligible) begin
                    state_next        = ST_GRANT;
                    count_next        = '0;
                    m1_grant_next     = !pick_m2;
                    m2_grant_next     = pick_m2;
                    bus_grant_next    = pick_m2 ? BUS_GRANT_M2 : BUS_GRANT_M1;
                    slave_select_next = pick_m2 ? M2_SLAVE_SEL : M1_SLAVE_SEL;
                    rr_m2_next        = !pick_m2;
                end
            end
            ST_GRANT: begin
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (TX_DONE) begin
                    state_next = ST_RELEASE;
                end else if (|(S_SPLIT_EN & slave_onehot(slave_select_reg)) && !split_pending) begin
                    split_record = 1'b1;
                    state_next   = ST_RELEASE;
                end else if (count_reg == COUNT_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = ST_RELEASE;
                end else begin
                    count_next = count_reg + 10'd1;
                end
                if (state_next == ST_RELEASE) begin
                    m1_grant_next  = 1'b0;
                    m2_grant_next  = 1'b0;
                    bus_grant_next = BUS_GRANT_NONE;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        arb_busy_next = (state_next != ST_IDLE);
        bus_busy_next = (state_next == ST_GRANT) || (state_next == ST_BUSY);
    end

endmodule
